// File: rtl/median_filter_pkg.sv
// Shared pixel types for the median filter pipeline and its output framer.
package median_filter_pkg;

   localparam int PIXEL_W = 8;

   typedef struct packed {
      logic [PIXEL_W-1:0] red;
      logic [PIXEL_W-1:0] green;
      logic [PIXEL_W-1:0] blue;
   } pixel_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      STREAMING = 2'd1,
      DRAIN     = 2'd2,
      DONE      = 2'd3
   } framer_state_t;

   typedef struct packed {
      pixel_t pixel;
      logic   sof;
      logic   eol;
   } framed_pixel_t;

endpackage

// File: rtl/pixel_valid_if.sv
// Valid-only pixel stream (no backpressure) between filter and framer.
interface pixel_valid_if;
   import median_filter_pkg::*;

   logic   valid;
   pixel_t pixel;

   modport master (output valid, output pixel);
   modport slave  (input valid, input pixel);
endinterface

// File: rtl/median_stream_framer_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on data_out whenever count is non-zero.
module pixel_fwft_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             data_in,
   input  logic                     pop,
   output logic [W-1:0]             data_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;
   logic          full_s;
   logic          empty_s;

   // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
   always_comb begin
      full_s    = (count_r == (AW+1)'(DEPTH));
      empty_s   = (count_r == {(AW+1){1'b0}});
      push_ok_s = push && !full_s;
      pop_ok_s  = pop && !empty_s;
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Head and status outputs.
   always_comb begin
      data_out = mem_r[rd_ptr_r];
      count    = count_r;
      full     = full_s;
      empty    = empty_s;
   end

endmodule

// File: rtl/median_stream_framer.sv
// Re-emits the median filter's valid-only pixel stream on a ready/valid port with
// start-of-frame / end-of-line tags, frame completion pulse and sticky overflow.
module median_stream_framer
   import median_filter_pkg::*;
#(
   parameter int FRAME_LEN    = 1079,
   parameter int FRAME_HEIGHT = 719,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   pixel_valid_if.slave        pixel_valid_if_i,
   output pixel_t              pixel_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic                sof_o,
   output logic                eol_o,
   output logic                frame_done_o,
   output logic                overflow_o,
   output logic                busy_o
);

   localparam int COL_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   framer_state_t state_r;
   framer_state_t state_s;
   logic [COL_W-1:0] col_r;
   logic [ROW_W-1:0] row_r;
   logic             overflow_r;
   logic             beat_s;
   logic             col_last_s;
   logic             row_last_s;
   logic             pop_s;
   framed_pixel_t    entry_s;
   framed_pixel_t    head_s;
   logic [CNT_W-1:0] count_s;
   logic             full_s;
   logic             empty_s;

   // Beat qualification and tagging of the incoming pixel.
   always_comb begin
      beat_s        = pixel_valid_if_i.valid && (state_r == STREAMING);
      col_last_s    = (col_r == COL_W'(FRAME_LEN - 1));
      row_last_s    = (row_r == ROW_W'(FRAME_HEIGHT - 1));
      entry_s.pixel = pixel_valid_if_i.pixel;
      entry_s.sof   = (col_r == {COL_W{1'b0}}) && (row_r == {ROW_W{1'b0}});
      entry_s.eol   = col_last_s;
      pop_s         = (count_s != {CNT_W{1'b0}}) && ready_i;
   end

   pixel_fwft_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     ($bits(framed_pixel_t))
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (beat_s),
      .data_in  (entry_s),
      .pop      (pop_s),
      .data_out (head_s),
      .count    (count_s),
      .full     (full_s),
      .empty    (empty_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; the final beat of the frame is still pushed as it moves to DRAIN.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_i) state_s = STREAMING;
            else         state_s = IDLE;
         end
         STREAMING: begin
            if (beat_s && col_last_s && row_last_s) state_s = DRAIN;
            else                                    state_s = STREAMING;
         end
         DRAIN: begin
            if (empty_s) state_s = DONE;
            else         state_s = DRAIN;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Position counters advance on every beat, dropped or not, so tags stay frame-aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_r      <= {COL_W{1'b0}};
         row_r      <= {ROW_W{1'b0}};
         overflow_r <= 1'b0;
      end else if ((state_r == IDLE) && start_i) begin
         col_r      <= {COL_W{1'b0}};
         row_r      <= {ROW_W{1'b0}};
         overflow_r <= 1'b0;
      end else if (beat_s) begin
         if (col_last_s) begin
            col_r <= {COL_W{1'b0}};
            row_r <= row_last_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
         end else begin
            col_r <= col_r + COL_W'(1);
         end
         if (full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // FSM / FIFO output decode; head fields are forced low when the FIFO is empty.
   always_comb begin
      valid_o      = (count_s != {CNT_W{1'b0}});
      if (valid_o) begin
         pixel_o = head_s.pixel;
         sof_o   = head_s.sof;
         eol_o   = head_s.eol;
      end else begin
         pixel_o = pixel_t'({$bits(pixel_t){1'b0}});
         sof_o   = 1'b0;
         eol_o   = 1'b0;
      end
      frame_done_o = (state_r == DONE);
      busy_o       = (state_r != IDLE);
      overflow_o   = overflow_r;
   end

endmodule

// File: tb/tb_median_stream_framer.sv
// Self-checking bench for median_stream_framer: queue-based frame model plus directed literal checks.
module tb_median_stream_framer;
   import median_filter_pkg::*;

   localparam int FL    = 4;
   localparam int FH    = 3;
   localparam int DEPTH = 4;
   localparam int NPIX  = FL * FH;

   typedef struct {
      pixel_t pix;
      logic   sof;
      logic   eol;
   } ent_t;

   logic   clk;
   logic   rst;
   logic   start_i;
   logic   ready_i;
   pixel_t pixel_o;
   logic   valid_o, sof_o, eol_o, frame_done_o, overflow_o, busy_o;

   pixel_valid_if pv ();

   median_stream_framer #(
      .FRAME_LEN    (FL),
      .FRAME_HEIGHT (FH),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start_i          (start_i),
      .pixel_valid_if_i (pv),
      .pixel_o          (pixel_o),
      .valid_o          (valid_o),
      .ready_i          (ready_i),
      .sof_o            (sof_o),
      .eol_o            (eol_o),
      .frame_done_o     (frame_done_o),
      .overflow_o       (overflow_o),
      .busy_o           (busy_o)
   );

   int n_checks = 0;
   int n_errs   = 0;
   int done_cnt = 0;
   ent_t pop_log [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic pixel_t mk(input logic [7:0] r);
      pixel_t p;
      p.red   = r;
      p.green = r ^ 8'h5a;
      p.blue  = ~r;
      return p;
   endfunction

   // Behavioural model: at each negedge compare, then advance with the inputs the next edge will sample.
   initial begin
      ent_t          mq [$];
      ent_t          e;
      framer_state_t mst;
      int            k;
      int            sz;
      bit            movf;
      bit            armed;
      armed = 1'b0;
      mst   = IDLE;
      k     = 0;
      movf  = 1'b0;
      forever begin
         @(negedge clk);
         if (armed) begin
            chk("valid_o", 32'(valid_o), 32'(mq.size() != 0));
            chk("busy_o", 32'(busy_o), 32'(mst != IDLE));
            chk("frame_done_o", 32'(frame_done_o), 32'(mst == DONE));
            chk("overflow_o", 32'(overflow_o), 32'(movf));
            if (mq.size() != 0) begin
               chk("pixel_o", 32'(pixel_o), 32'(mq[0].pix));
               chk("sof_o", 32'(sof_o), 32'(mq[0].sof));
               chk("eol_o", 32'(eol_o), 32'(mq[0].eol));
            end else begin
               chk("sof_o_idle", 32'(sof_o), 32'(0));
               chk("eol_o_idle", 32'(eol_o), 32'(0));
            end
            if (frame_done_o) done_cnt++;
            if (valid_o && ready_i) begin
               e.pix = pixel_o;
               e.sof = sof_o;
               e.eol = eol_o;
               pop_log.push_back(e);
            end
         end
         if (rst) begin
            mq.delete();
            mst   = IDLE;
            k     = 0;
            movf  = 1'b0;
            armed = 1'b1;
         end else begin
            sz = mq.size();
            case (mst)
               IDLE: if (start_i) begin
                  mst  = STREAMING;
                  k    = 0;
                  movf = 1'b0;
               end
               STREAMING: if (pv.valid) begin
                  e.pix = pv.pixel;
                  e.sof = (k == 0);
                  e.eol = ((k % FL) == FL - 1);
                  if (sz == DEPTH) movf = 1'b1;
                  else             mq.push_back(e);
                  if (k == NPIX - 1) mst = DRAIN;
                  k = (k + 1) % NPIX;
               end
               DRAIN: if (sz == 0) mst = DONE;
               DONE:  mst = IDLE;
               default: mst = IDLE;
            endcase
            if (sz != 0 && ready_i) void'(mq.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] r);
      pv.valid = 1'b1;
      pv.pixel = mk(r);
      tick();
      pv.valid = 1'b0;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 200; n++) begin
         if (!busy_o) break;
         tick();
      end
      chk("idle_timeout", 32'(busy_o), 32'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int nb;
      int sofs;
      rst      = 1'b1;
      start_i  = 1'b0;
      ready_i  = 1'b0;
      pv.valid = 1'b0;
      pv.pixel = mk(8'd0);
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 32'(valid_o), 32'(0));
      chk("rst_busy", 32'(busy_o), 32'(0));
      chk("rst_ovf", 32'(overflow_o), 32'(0));
      chk("rst_done", 32'(frame_done_o), 32'(0));

      // 1: back-to-back frame, ready always high
      ready_i = 1'b1;
      pop_log.delete();
      done_cnt = 0;
      do_start();
      beat(8'd0);
      chk("t1_lat_valid", 32'(valid_o), 32'(1));
      chk("t1_lat_red", 32'(pixel_o.red), 32'(0));
      chk("t1_lat_sof", 32'(sof_o), 32'(1));
      for (int i = 1; i < NPIX; i++) beat(8'(i));
      wait_idle();
      chk("t1_npop", 32'(pop_log.size()), 32'(12));
      sofs = 0;
      for (int i = 0; i < pop_log.size(); i++) begin
         chk("t1_red", 32'(pop_log[i].pix.red), 32'(i));
         chk("t1_eol", 32'(pop_log[i].eol), 32'((i == 3) || (i == 7) || (i == 11)));
         sofs += int'(pop_log[i].sof);
      end
      chk("t1_sof_cnt", 32'(sofs), 32'(1));
      chk("t1_done_cnt", 32'(done_cnt), 32'(1));
      chk("t1_ovf", 32'(overflow_o), 32'(0));

      // 2: stalled output, overflow, then release
      ready_i = 1'b0;
      pop_log.delete();
      done_cnt = 0;
      do_start();
      for (int i = 0; i < 4; i++) beat(8'(i));
      chk("t2_ovf_before", 32'(overflow_o), 32'(0));
      beat(8'd4);
      chk("t2_ovf_after", 32'(overflow_o), 32'(1));
      beat(8'd5);
      chk("t2_head_valid", 32'(valid_o), 32'(1));
      chk("t2_head_red", 32'(pixel_o.red), 32'(0));
      ready_i = 1'b1;
      for (int i = 6; i < NPIX; i++) beat(8'(i));
      wait_idle();
      for (int i = 0; i < 4; i++) chk("t2_red", 32'(pop_log[i].pix.red), 32'(i));
      chk("t2_done_cnt", 32'(done_cnt), 32'(1));

      // 3: full FIFO, push and pop on the same edge: the push is still dropped
      ready_i = 1'b0;
      pop_log.delete();
      do_start();
      for (int i = 0; i < 4; i++) beat(8'(i));
      ready_i = 1'b1;
      beat(8'd4);
      chk("t3_ovf", 32'(overflow_o), 32'(1));
      for (int i = 5; i < NPIX; i++) beat(8'(i));
      wait_idle();
      chk("t3_pop4_red", 32'(pop_log[4].pix.red), 32'(5));
      chk("t3_npop", 32'(pop_log.size()), 32'(11));

      // 4: beats in IDLE and in DRAIN are ignored
      pop_log.delete();
      for (int i = 0; i < 5; i++) begin
         beat(8'(100 + i));
         chk("t4_idle_valid", 32'(valid_o), 32'(0));
      end
      ready_i = 1'b0;
      do_start();
      for (int i = 0; i < NPIX; i++) beat(8'(i));
      for (int i = 0; i < 5; i++) beat(8'(200 + i));
      ready_i = 1'b1;
      wait_idle();
      chk("t4_npop", 32'(pop_log.size()), 32'(4));
      chk("t4_sof", 32'(pop_log[0].sof), 32'(1));
      chk("t4_last_red", 32'(pop_log[3].pix.red), 32'(3));

      // 5: reset mid-frame with three entries buffered
      ready_i = 1'b0;
      do_start();
      for (int i = 0; i < 3; i++) beat(8'(i));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_valid", 32'(valid_o), 32'(0));
      chk("t5_busy", 32'(busy_o), 32'(0));
      chk("t5_sof", 32'(sof_o), 32'(0));
      pop_log.delete();
      ready_i = 1'b1;
      do_start();
      for (int i = 0; i < NPIX; i++) beat(8'(50 + i));
      wait_idle();
      chk("t5_first_sof", 32'(pop_log[0].sof), 32'(1));
      chk("t5_first_red", 32'(pop_log[0].pix.red), 32'(50));

      // Randomised frames: sparse input, throttled output, stray start pulses, one mid-frame reset
      for (int f = 0; f < 16; f++) begin
         do_start();
         nb = 0;
         while (nb < NPIX) begin
            pv.valid = ($urandom_range(0, 9) < 6);
            pv.pixel = pixel_t'(24'($urandom));
            ready_i  = ($urandom_range(0, 3) != 0);
            start_i  = ($urandom_range(0, 7) == 0);
            rst      = (f == 7) && (nb == 5);
            if (pv.valid) nb++;
            tick();
            if (rst) begin
               nb = NPIX;
               rst = 1'b0;
            end
         end
         pv.valid = 1'b0;
         start_i  = 1'b0;
         for (int n = 0; n < 300 && busy_o; n++) begin
            pv.valid = $urandom_range(0, 1);
            ready_i  = ($urandom_range(0, 1) != 0);
            tick();
         end
         pv.valid = 1'b0;
         chk("rand_idle", 32'(busy_o), 32'(0));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/median_stream_framer.md
Name: median_stream_framer

Overview:
- Downstream stage of the median filter.
- Consumes the filter's valid-only output pixel stream, which has no backpressure and a frame of FRAME_LEN x FRAME_HEIGHT pixels.
- Buffers the stream in a small first-word-fall-through FIFO and re-emits it on a ready/valid interface, tagging start-of-frame and end-of-line.
- Reports frame completion and sticky overflow to the control/DMA logic.

Parameters:
- FRAME_LEN, 1079, output pixels per line (filter IMAGE_LEN-1).
- FRAME_HEIGHT, 719, output lines per frame (filter IMAGE_HEIGHT-1).
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  arm for one frame; sampled only in IDLE
- pixel_valid_if_i  slave  pixel_valid_if  upstream pixel plus valid; no ready
- pixel_o  out  $bits(pixel_t)  FIFO head pixel
- valid_o  out  1  head entry present
- ready_i  in  1  downstream accept
- sof_o  out  1  head is pixel (0,0)
- eol_o  out  1  head is last pixel of a line
- frame_done_o  out  1  single-cycle pulse after frame fully drained
- overflow_o  out  1  sticky: at least one pixel dropped this frame
- busy_o  out  1  state != IDLE

Behaviour:
- Clock, reset and reset values
  - clk is the only clock; rst is synchronous and active-high.
  - Reset (including mid-frame) forces: state IDLE, FIFO empty, counters 0, valid_o=0, sof_o=0, eol_o=0, frame_done_o=0, overflow_o=0, busy_o=0.
  - pixel_o is don't-care while valid_o=0.
- States
  - IDLE: input beats are ignored. On start_i: go to STREAMING, clear col/row counters, clear overflow_o.
  - STREAMING: input beats are accepted. The beat with col==FRAME_LEN-1 and row==FRAME_HEIGHT-1 moves the state to DRAIN; that beat is itself processed normally.
  - DRAIN: input beats are ignored. When FIFO count==0, go to DONE.
  - DONE: drive frame_done_o=1 for exactly one cycle, then go to IDLE.
  - start_i outside IDLE is ignored.
- Write side (input beat = pixel_valid_if_i.valid in STREAMING)
  - Entry = {pixel, sof, eol}.
  - sof = (col==0 && row==0); eol = (col==FRAME_LEN-1).
  - Counters advance on every input beat, including dropped ones, so tagging stays frame-aligned.
  - col wraps to 0 at FRAME_LEN-1 and row increments at that point.
  - Push only if the registered count < FIFO_DEPTH.
  - If full, the pixel is dropped and overflow_o is set next cycle; a simultaneous pop does NOT rescue the push.
- Read side
  - valid_o = (count != 0); pixel_o, sof_o and eol_o are the head entry.
  - Pop when valid_o && ready_i.
  - Head must hold stable while valid_o && !ready_i.
- Latency and count
  - Push at edge N makes the entry visible at valid_o after edge N, i.e. 1 cycle. There is no combinational bypass from input to output.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- frame_done_o fires even if pixels were dropped; DRAIN depends only on count reaching 0.

Decomposition:
- median_filter_pkg (existing): pixel_t and PIXEL_W are reused.
- Add to median_filter_pkg:
  - framer_state_t enum {IDLE, STREAMING, DRAIN, DONE}.
  - framed_pixel_t struct {pixel_t pixel; logic sof; logic eol}.
- Sub-module pixel_fwft_fifo, parameterised by DEPTH and entry type width.
  - Interface: push/data_in, pop/data_out, count, full, empty.
  - Contains the registered count and pointers.
- Top level holds the FSM, the counters, tagging and overflow.

Test Plan (FRAME_LEN=4, FRAME_HEIGHT=3, FIFO_DEPTH=4 unless noted):
1. start_i, then 12 back-to-back beats with pixel red=i, ready_i=1 -> 12 outputs in order, each 1 cycle after input; sof_o only on i=0; eol_o on i=3, 7 and 11; frame_done_o pulses once, 2 cycles after the last pop; overflow_o=0.
2. ready_i=0, 6 beats -> valid_o high with head red=0 held stable; beats 4 and 5 dropped; overflow_o=1 from the cycle after beat 4. Then ready_i=1 -> outputs red=0..3, then DRAIN completes; frame_done_o fires.
3. FIFO full with ready_i=1 and a push in the same cycle -> push dropped, overflow_o=1, count drops to 3.
4. Valid beats while IDLE, and again in DRAIN -> no FIFO writes, valid_o stays 0, counters unchanged.
5. rst asserted mid-frame with count=3 -> next cycle all outputs 0 and state IDLE. A new start_i plus 12 beats yields sof_o on the first output.
6. FRAME_LEN=1079, FRAME_HEIGHT=719, random ready_i with ≥50% duty, input valid every 2nd cycle -> 775801 outputs, 719 eol_o pulses, overflow_o=0, one frame_done_o.
